// File: rtl/usb_spi_responder_pkg.sv
// Shared types and constants for the USB SPI responder.
// Status-byte helper is only referenced when STATUS_BYTE_EN is defined.
package usb_spi_pkg;
    localparam int REG_AW     = 5;
    localparam int BYTE_W     = 8;
    localparam int NUM_REGS   = 32;
    localparam int FIFO_DEPTH = 8;

    localparam logic [REG_AW-1:0] FIFO_ADDR_DEF = 5'd1;
    localparam logic [REG_AW-1:0] IEN_ADDR_DEF  = 5'd13;

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} spi_state_t;

    function automatic logic [BYTE_W-1:0] status_byte(input logic irq_pend,
                                                      input logic full,
                                                      input logic nonempty);
        return {irq_pend, full, nonempty, 5'b0};
    endfunction
endpackage

// File: rtl/usb_spi_responder_if.sv
// SPI link and fabric-side keycode FIFO signals of the USB SPI responder.
interface usb_spi_responder_if;
    import usb_spi_pkg::*;

    logic                spi_ss_n;
    logic                spi_sclk;
    logic                spi_mosi;
    logic                spi_miso;
    logic                spi_miso_oe;
    logic                irq_n;
    logic                fifo_push;
    logic [BYTE_W-1:0]   fifo_wdata;
    logic                fifo_full;
    logic [3:0]          fifo_count;

    modport master (
        output spi_ss_n, spi_sclk, spi_mosi, fifo_push, fifo_wdata,
        input  spi_miso, spi_miso_oe, irq_n, fifo_full, fifo_count
    );

    modport slave (
        input  spi_ss_n, spi_sclk, spi_mosi, fifo_push, fifo_wdata,
        output spi_miso, spi_miso_oe, irq_n, fifo_full, fifo_count
    );
endinterface

// File: rtl/usb_spi_responder_key_fifo.sv
// Keycode FIFO: synchronous push/pop, head always visible, count and full flags.
module usb_key_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    // A pop in the same clk frees the slot, so a push while full still lands.
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
endmodule

// File: rtl/usb_spi_responder.sv
// SPI mode-0 slave with 32x8 register file, keycode FIFO and active-low IRQ.
// Optional STATUS_BYTE_EN: status byte is shifted out during the command byte.
//  state | meaning
//  IDLE  | ss_n high, waiting for select
//  CMD   | receiving command byte
//  WR    | receiving data bytes, commit each to reg[addr]
//  RD    | sending reg[addr] or FIFO head, pop per completed byte
module usb_spi_responder
    import usb_spi_pkg::*;
#(
    parameter logic [REG_AW-1:0] FIFO_ADDR = FIFO_ADDR_DEF,
    parameter logic [REG_AW-1:0] IEN_ADDR  = IEN_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    usb_spi_responder_if.slave bus
);
    logic r_ss_meta, r_ss_sync;
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_mosi_meta, r_mosi_sync;

    spi_state_t          r_state;
    logic [2:0]          r_bit_cnt;
    logic [BYTE_W-1:0]   r_shift_in;
    logic [BYTE_W-1:0]   r_shift_out;
    logic                r_miso;
    logic [REG_AW-1:0]   r_addr;
    logic                r_reload;
    logic                r_irq_n;
    logic [BYTE_W-1:0]   r_regs [NUM_REGS];

    logic                w_rise, w_fall, w_byte_done, w_pop;
    logic [BYTE_W-1:0]   w_byte, w_fifo_head, w_fifo_data, w_cmd_rdata, w_cur_rdata;
    logic [REG_AW-1:0]   w_cmd_addr;
    logic [3:0]          w_fifo_count;
    logic                w_fifo_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ss_meta   <= 1'b1;
            r_ss_sync   <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_ss_meta   <= bus.spi_ss_n;
            r_ss_sync   <= r_ss_meta;
            r_sclk_meta <= bus.spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= bus.spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_rise      = r_sclk_sync & ~r_sclk_prev;
    assign w_fall      = ~r_sclk_sync & r_sclk_prev;
    assign w_byte      = {r_shift_in[BYTE_W-2:0], r_mosi_sync};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
    assign w_cmd_addr  = w_byte[7:3];
    assign w_fifo_data = (w_fifo_count != '0) ? w_fifo_head : '0;
    assign w_cmd_rdata = (w_cmd_addr == FIFO_ADDR) ? w_fifo_data : r_regs[w_cmd_addr];
    assign w_cur_rdata = (r_addr == FIFO_ADDR) ? w_fifo_data : r_regs[r_addr];
    assign w_pop       = (r_state == RD) && !r_ss_sync && w_byte_done && (r_addr == FIFO_ADDR);

`ifdef STATUS_BYTE_EN
    logic [BYTE_W-1:0] w_status;
    assign w_status = status_byte(~r_irq_n, w_fifo_full, w_fifo_count != '0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_miso      <= 1'b0;
            r_addr      <= '0;
            r_reload    <= 1'b0;
            r_irq_n     <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_reload <= 1'b0;
            r_irq_n  <= ~(r_regs[IEN_ADDR][0] & (w_fifo_count != '0));
            // r_miso holds the bit on the wire; r_shift_out is the queue behind it.
            if (w_fall) begin
                r_miso      <= r_shift_out[BYTE_W-1];
                r_shift_out <= {r_shift_out[BYTE_W-2:0], 1'b0};
            end
            if (r_ss_sync) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= CMD;
                        r_bit_cnt  <= '0;
                        r_shift_in <= '0;
`ifdef STATUS_BYTE_EN
                        r_miso      <= w_status[BYTE_W-1];
                        r_shift_out <= {w_status[BYTE_W-2:0], 1'b0};
`else
                        r_miso      <= 1'b0;
                        r_shift_out <= '0;
`endif
                    end
                    CMD: if (w_rise) begin
                        r_shift_in <= w_byte;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (w_byte_done) begin
                            r_addr <= w_cmd_addr;
                            if (w_byte[1]) begin
                                r_state <= WR;
                            end else begin
                                r_state     <= RD;
                                r_shift_out <= w_cmd_rdata;
                            end
                        end
                    end
                    WR: if (w_rise) begin
                        r_shift_in <= w_byte;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (w_byte_done && (r_addr != FIFO_ADDR)) r_regs[r_addr] <= w_byte;
                    end
                    RD: begin
                        // Reload one clk after the pop so the new head is visible.
                        if (r_reload) r_shift_out <= w_cur_rdata;
                        if (w_rise) begin
                            r_shift_in <= w_byte;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            r_reload   <= w_byte_done;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    usb_key_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (bus.fifo_push),
        .i_wdata (bus.fifo_wdata),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full)
    );

    assign bus.spi_miso    = r_miso;
    assign bus.spi_miso_oe = ~r_ss_sync;
    assign bus.irq_n       = r_irq_n;
    assign bus.fifo_full   = w_fifo_full;
    assign bus.fifo_count  = w_fifo_count;
endmodule
